// File: rtl/arinc429_rx_if.sv
// ARINC-429 RX channel bus: line comparator legs in, assembled words and strobes out.
interface arinc429_rx_if;
    logic        rx_en;
    logic        speed_hi;
    logic        line_hi;
    logic        line_lo;
    logic [31:0] rx_word;
    logic        rx_valid;
    logic        rx_par_err;
    logic        rx_frm_err;

    // Driver of the line / consumer of words
    modport master (
        output rx_en, speed_hi, line_hi, line_lo,
        input  rx_word, rx_valid, rx_par_err, rx_frm_err
    );

    // Deserializer side
    modport slave (
        input  rx_en, speed_hi, line_hi, line_lo,
        output rx_word, rx_valid, rx_par_err, rx_frm_err
    );
endinterface

// File: rtl/arinc429_rx_deser.sv
// ARINC-429 receive deserializer: synchronizes and filters the HI/LO comparator legs,
// decodes RZ bipolar bits and assembles 32-bit words with parity and framing flags.
module arinc429_rx_deser #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TOUT_HS  = 1000,
    parameter int unsigned TOUT_LS  = 8000,
    parameter int unsigned TW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arinc429_rx_if.slave  bus
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);
    localparam int unsigned BW = 6;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_BITNULL = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      hi_sync, lo_sync;
    logic [1:0]      sync_pair, cand, filt, filt_d;
    logic [CW-1:0]   run_cnt, run_nxt;
    logic [TW-1:0]   timer, tout;
    logic [BW-1:0]   bit_cnt;
    logic [31:0]     word;
    logic [31:0]     rx_word_q;
    logic            rx_valid_q, rx_par_err_q, rx_frm_err_q;
    logic            is_null, is_ill, is_bit, chg, timeout;
    logic            frm_c, done_c, store_c;

    assign sync_pair = {hi_sync[1], lo_sync[1]};
    assign is_null   = (filt == 2'b00);
    assign is_ill    = (filt == 2'b11);
    assign is_bit    = (filt == 2'b10) || (filt == 2'b01);
    assign chg       = (filt != filt_d);
    assign tout      = bus.speed_hi ? TW'(TOUT_HS) : TW'(TOUT_LS);
    assign timeout   = (timer >= (tout - TW'(1)));

    // Two-flop synchronizer per comparator leg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_sync <= 2'b00;
            lo_sync <= 2'b00;
        end else begin
            hi_sync <= {hi_sync[0], bus.line_hi};
            lo_sync <= {lo_sync[0], bus.line_lo};
        end
    end

    // Length of the current run of identical synchronized samples, saturating at FILT_LEN
    always_comb begin
        run_nxt = CW'(1);
        if (sync_pair == cand) begin
            run_nxt = (run_cnt >= CW'(FILT_LEN)) ? run_cnt : run_cnt + CW'(1);
        end
    end

    // Glitch filter: accept a new line state once it has been stable FILT_LEN samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand    <= 2'b00;
            run_cnt <= '0;
            filt    <= 2'b00;
            filt_d  <= 2'b00;
        end else begin
            cand    <= sync_pair;
            run_cnt <= run_nxt;
            if (run_nxt >= CW'(FILT_LEN)) begin
                filt <= sync_pair;
            end
            filt_d  <= filt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC: begin
                if (is_null && timeout) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (is_ill)      state_nxt = ST_SYNC;
                else if (is_bit) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (is_ill)                 state_nxt = ST_SYNC;
                else if (is_null)           state_nxt = (bit_cnt == BW'(32)) ? ST_IDLE : ST_BITNULL;
                else if (chg || timeout)    state_nxt = ST_SYNC;
            end
            ST_BITNULL: begin
                if (is_ill)       state_nxt = ST_SYNC;
                else if (is_bit)  state_nxt = ST_ACTIVE;
                else if (timeout) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_SYNC;
        endcase
        if (!bus.rx_en) state_nxt = ST_SYNC;
    end

    // FSM action decode: bit store, word completion and framing abort
    always_comb begin
        frm_c   = 1'b0;
        done_c  = 1'b0;
        store_c = 1'b0;
        case (state)
            ST_IDLE: begin
                store_c = is_bit;
            end
            ST_ACTIVE: begin
                if (is_ill)                 frm_c  = 1'b1;
                else if (is_null)           done_c = (bit_cnt == BW'(32));
                else if (chg || timeout)    frm_c  = 1'b1;
            end
            ST_BITNULL: begin
                if (is_bit)                     store_c = 1'b1;
                else if (is_ill || timeout)     frm_c   = 1'b1;
            end
            default: ;
        endcase
        if (!bus.rx_en) begin
            frm_c   = 1'b0;
            done_c  = 1'b0;
            store_c = 1'b0;
        end
    end

    // Shift register, bit counter and gap/bit timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word    <= '0;
            bit_cnt <= '0;
            timer   <= '0;
        end else if (!bus.rx_en) begin
            bit_cnt <= '0;
            timer   <= '0;
        end else begin
            if (store_c) begin
                word[bit_cnt[4:0]] <= filt[1];
                bit_cnt            <= bit_cnt + BW'(1);
            end else if (state_nxt == ST_IDLE || state_nxt == ST_SYNC) begin
                bit_cnt <= '0;
            end
            if (state_nxt != state || chg || (state == ST_SYNC && !is_null)) begin
                timer <= '0;
            end else if (timer != {TW{1'b1}}) begin
                timer <= timer + TW'(1);
            end
        end
    end

    // Registered word output and one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_word_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_par_err_q <= 1'b0;
            rx_frm_err_q <= 1'b0;
        end else begin
            rx_valid_q   <= done_c;
            rx_par_err_q <= done_c & ~(^word);
            rx_frm_err_q <= frm_c;
            if (done_c) begin
                rx_word_q <= word;
            end
        end
    end

    assign bus.rx_word    = rx_word_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_par_err = rx_par_err_q;
    assign bus.rx_frm_err = rx_frm_err_q;

endmodule

// File: tb/tb_arinc429_rx_deser.sv
// Directed bench for arinc429_rx_deser with shortened timeouts (bit time 20/40 clks).
module tb_arinc429_rx_deser;

    localparam int unsigned FILT_LEN = 4;
    localparam int unsigned TOUT_HS  = 40;
    localparam int unsigned TOUT_LS  = 80;
    localparam int unsigned TW       = 16;
    localparam int HS_HALF = 10;
    localparam int LS_HALF = 20;

    logic clk = 1'b0;
    logic rst_n;

    arinc429_rx_if bus();

    arinc429_rx_deser #(
        .FILT_LEN (FILT_LEN),
        .TOUT_HS  (TOUT_HS),
        .TOUT_LS  (TOUT_LS),
        .TW       (TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_frm = 0;
    int n_overlap = 0;
    logic [31:0] last_word = '0;
    logic        last_par = 1'b0;
    int v0, f0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) begin
                n_valid++;
                last_word = bus.rx_word;
                last_par  = bus.rx_par_err;
            end
            if (bus.rx_frm_err) n_frm++;
            if (bus.rx_valid && bus.rx_frm_err) n_overlap++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send bits w[0..nbits-1] RZ; bit ill_at is sent as HI=LO=1; glitch adds a 2-clk HI pulse in each null
    task automatic send_bits(input logic [31:0] w, input int nbits, input int half,
                             input bit glitch, input int ill_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == ill_at) begin
                bus.line_hi = 1'b1; bus.line_lo = 1'b1;
            end else begin
                bus.line_hi = w[i]; bus.line_lo = ~w[i];
            end
            tick(half);
            bus.line_hi = 1'b0; bus.line_lo = 1'b0;
            if (glitch) begin
                tick(3); bus.line_hi = 1'b1;
                tick(2); bus.line_hi = 1'b0;
                tick(half - 5);
            end else begin
                tick(half);
            end
        end
    endtask

    task automatic mark();
        v0 = n_valid;
        f0 = n_frm;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.rx_en = 1'b0; bus.speed_hi = 1'b1;
        bus.line_hi = 1'b0; bus.line_lo = 1'b0;
        tick(3);
        check("rst_word",  bus.rx_word, 32'h0);
        check("rst_valid", 32'(bus.rx_valid), 32'h0);
        check("rst_par",   32'(bus.rx_par_err), 32'h0);
        check("rst_frm",   32'(bus.rx_frm_err), 32'h0);
        rst_n = 1'b1;
        bus.rx_en = 1'b1;
        tick(60);

        // T1: 0x000000A1 has 3 ones -> odd parity, accepted clean
        mark();
        send_bits(32'h0000_00A1, 32, HS_HALF, 1'b0, -1);
        tick(30);
        check("t1_nvalid", 32'(n_valid - v0), 32'd1);
        check("t1_word",   last_word, 32'h0000_00A1);
        check("t1_par",    32'(last_par), 32'h0);
        check("t1_frm",    32'(n_frm - f0), 32'd0);
        check("t1_port",   bus.rx_word, 32'h0000_00A1);

        // T2: 0x800000A1 has 4 ones -> parity error, word still delivered
        mark();
        send_bits(32'h8000_00A1, 32, HS_HALF, 1'b0, -1);
        tick(30);
        check("t2_nvalid", 32'(n_valid - v0), 32'd1);
        check("t2_word",   last_word, 32'h8000_00A1);
        check("t2_par",    32'(last_par), 32'h1);

        // T3: 20 bits then long null -> timeout abort, then a full word
        mark();
        send_bits(32'h0000_FFFF, 20, HS_HALF, 1'b0, -1);
        tick(60);
        check("t3_frm",    32'(n_frm - f0), 32'd1);
        check("t3_nvalid", 32'(n_valid - v0), 32'd0);
        check("t3_hold",   bus.rx_word, 32'h8000_00A1);
        mark();
        send_bits(32'h8000_0001, 32, HS_HALF, 1'b0, -1);
        tick(30);
        check("t3_nvalid2", 32'(n_valid - v0), 32'd1);
        check("t3_word2",   last_word, 32'h8000_0001);
        check("t3_par2",    32'(last_par), 32'h1);
        check("t3_frm2",    32'(n_frm - f0), 32'd0);

        // T4: illegal level at bit 10, word without a full gap ignored, then gap + good word
        mark();
        send_bits(32'h5555_5555, 32, HS_HALF, 1'b0, 10);
        send_bits(32'h0000_0007, 32, HS_HALF, 1'b0, -1);
        tick(80);
        send_bits(32'h8000_0003, 32, HS_HALF, 1'b0, -1);
        tick(30);
        check("t4_frm",    32'(n_frm - f0), 32'd1);
        check("t4_nvalid", 32'(n_valid - v0), 32'd1);
        check("t4_word",   last_word, 32'h8000_0003);
        check("t4_par",    32'(last_par), 32'h0);

        // T5: short HI pulses inside every inter-bit null are filtered out
        mark();
        send_bits(32'h1234_5678, 32, HS_HALF, 1'b1, -1);
        tick(30);
        check("t5_nvalid", 32'(n_valid - v0), 32'd1);
        check("t5_word",   last_word, 32'h1234_5678);
        check("t5_par",    32'(last_par), 32'h0);
        check("t5_frm",    32'(n_frm - f0), 32'd0);

        // Channel disabled mid-word: silent discard, rx_word retained
        mark();
        send_bits(32'hFFFF_FFFF, 12, HS_HALF, 1'b0, -1);
        bus.rx_en = 1'b0;
        send_bits(32'hFFFF_FFFF, 20, HS_HALF, 1'b0, -1);
        tick(20);
        bus.rx_en = 1'b1;
        tick(60);
        check("en_frm",    32'(n_frm - f0), 32'd0);
        check("en_nvalid", 32'(n_valid - v0), 32'd0);
        check("en_hold",   bus.rx_word, 32'h1234_5678);

        // T6: low speed, two words with 4-bit-time gaps
        bus.speed_hi = 1'b0;
        tick(10);
        mark();
        send_bits(32'hA5A5_A5A5, 32, LS_HALF, 1'b0, -1);
        tick(4 * 2 * LS_HALF);
        check("t6_word1", last_word, 32'hA5A5_A5A5);
        check("t6_par1",  32'(last_par), 32'h1);
        send_bits(32'h0000_0001, 32, LS_HALF, 1'b0, -1);
        tick(4 * 2 * LS_HALF);
        check("t6_nvalid", 32'(n_valid - v0), 32'd2);
        check("t6_word2",  last_word, 32'h0000_0001);
        check("t6_par2",   32'(last_par), 32'h0);
        check("t6_frm",    32'(n_frm - f0), 32'd0);

        // Reset in the middle of a third word
        mark();
        send_bits(32'hFFFF_0000, 8, LS_HALF, 1'b0, -1);
        bus.line_hi = 1'b1;
        tick(5);
        rst_n = 1'b0;
        bus.line_hi = 1'b0;
        tick(1);
        check("mid_rst_word",  bus.rx_word, 32'h0);
        check("mid_rst_valid", 32'(bus.rx_valid), 32'h0);
        check("mid_rst_frm",   32'(bus.rx_frm_err), 32'h0);
        tick(5);
        rst_n = 1'b1;
        tick(200);
        check("post_rst_nvalid", 32'(n_valid - v0), 32'd0);
        check("post_rst_frm",    32'(n_frm - f0), 32'd0);
        check("post_rst_word",   bus.rx_word, 32'h0);

        check("overlap", 32'(n_overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
